// File: rtl/uart_tx_arbiter_pkg.sv
// Shared state encoding, default timing constants and width helper for the
// UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  localparam int DEF_GAP_CYCLES  = 16;
  localparam int DEF_ACK_TIMEOUT = 64;

  // Number of bits needed to index 'value' distinct items.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        bits = i + 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin winner selection; the pointer advances only when the offered
// grant is actually accepted.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] last_grant_r;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  int               sum_s;

  assign any_req = |req;

  // Search starts just past the last accepted requester and wraps once.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    sum_s     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_s  = (int'(last_grant_r) + k) % NUM_REQ;
      cand_s = IDX_W'(sum_s);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Reset value makes requester 0 the first in line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_r <= IDX_W'(NUM_REQ - 1);
    end else if (accept) begin
      last_grant_r <= grant_idx;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources: round-robin accept,
// start pulse, ack/done handshake with timeout, and an enforced inter-frame gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_W      = 8,
  parameter int  GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int  ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int IDX_W       = (clog2(NUM_REQ) > 0) ? clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      err_timeout
);

  localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
  localparam int CNT_W   = (clog2(CNT_MAX + 1) > 0) ? clog2(CNT_MAX + 1) : 1;
  // The ack window is measured from the tx_start cycle, one cycle before WAIT_ACK
  // is entered, and the error flag is registered, hence the offset of two.
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'((ACK_TIMEOUT >= 2) ? ACK_TIMEOUT - 2 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                tx_start_r;
  logic [DATA_W-1:0]   tx_data_r;
  logic [IDX_W-1:0]    grant_id_r;
  logic                busy_r;
  logic                err_r;

  logic [NUM_REQ-1:0]  grant_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                any_s;
  logic                offer_s;
  logic                accept_s;
  logic [DATA_W-1:0]   win_data_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept_s),
    .grant     (grant_s),
    .grant_idx (win_idx_s),
    .any_req   (any_s)
  );

  // Ready is offered only in IDLE and is forced low while reset is held.
  assign offer_s    = (state_r == ST_IDLE) && rst;
  assign accept_s   = offer_s && any_s;
  assign req_ready  = offer_s ? grant_s : '0;
  assign win_data_s = req_data[win_idx_s*DATA_W +: DATA_W];

  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign err_timeout = err_r;

  // Frame sequencing FSM with registered outputs; counter cleared on each state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      grant_id_r <= '0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_START;
            cnt_r      <= '0;
            tx_start_r <= 1'b1;
            tx_data_r  <= win_data_s;
            grant_id_r <= win_idx_s;
            busy_r     <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_START: begin
          state_r <= ST_WAIT_ACK;
          cnt_r   <= '0;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state_r <= ST_WAIT_DONE;
            cnt_r   <= '0;
          end else if (cnt_r >= ACK_LAST) begin
            // Unacknowledged byte is dropped; no retry.
            err_r <= 1'b1;
            cnt_r <= '0;
            if (GAP_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_GAP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            cnt_r <= '0;
            if (GAP_CYCLES == 0) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_GAP;
            end
          end else begin
            cnt_r <= '0;
          end
        end
        ST_GAP: begin
          if (cnt_r >= GAP_LAST) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default build plus a GAP_CYCLES = 0 build.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_data;
  logic        tx_busy, tx_start, busy, err_timeout;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  logic [3:0]  req_valid_g, req_ready_g;
  logic [31:0] req_data_g;
  logic        tx_busy_g, tx_start_g, busy_g, err_timeout_g;
  logic [7:0]  tx_data_g;
  logic [1:0]  grant_id_g;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_order [4] = '{2, 3, 0, 2};

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
  );

  uart_tx_arbiter #(.GAP_CYCLES(0)) dut_g (
    .clk(clk), .rst(rst), .req_valid(req_valid_g), .req_data(req_data_g),
    .req_ready(req_ready_g), .tx_busy(tx_busy_g), .tx_start(tx_start_g),
    .tx_data(tx_data_g), .grant_id(grant_id_g), .busy(busy_g), .err_timeout(err_timeout_g)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    req_valid   = '0;
    req_valid_g = '0;
    tx_busy     = 1'b0;
    tx_busy_g   = 1'b0;
    rst         = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Called in the tx_start cycle: ack next cycle, hold busy for len cycles.
  task automatic frame_busy(input int len);
    step();
    tx_busy = 1'b1;
    repeat (len) step();
    tx_busy = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hFFFF_FFFF;
    tx_busy   = 1'b0;
    req_valid_g = '0; req_data_g = '0; tx_busy_g = 1'b0;
    step();
    checks++;
    if ({tx_start, tx_data, grant_id, busy, err_timeout} !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: got %h expected 000", {tx_start, tx_data, grant_id, busy, err_timeout});
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
  endtask

  task automatic test_single();
    int n;
    apply_reset();
    req_data  = 32'h0000_0095;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b expected 1", tx_start); end
    checks++;
    if (tx_data !== 8'h95) begin errors++; $display("FAIL single_data: got %h expected 95", tx_data); end
    checks++;
    if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    step();
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_width: got %b expected 0", tx_start); end
    tx_busy = 1'b1;
    repeat (4) step();
    tx_busy = 1'b0;
    wait_idle(n);
    checks++;
    if (n !== 17) begin errors++; $display("FAIL single_gap: got %0d cycles expected 17", n); end
  endtask

  task automatic test_round_robin();
    int n;
    int prev;
    apply_reset();
    req_data  = 32'hA3A2_A1A0;
    req_valid = 4'b1111;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== (4'b0001 << i)) begin errors++; $display("FAIL rr_ready%0d: got %b expected %b", i, req_ready, 4'b0001 << i); end
      step();
      req_valid[i] = 1'b0;
      checks++;
      if (tx_start !== 1'b1 || grant_id !== 2'(i)) begin
        errors++; $display("FAIL rr_start%0d: got start=%b id=%0d expected start=1 id=%0d", i, tx_start, grant_id, i);
      end
      checks++;
      if (tx_data !== 8'(8'hA0 + i)) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", i, tx_data, 8'(8'hA0 + i)); end
      if (i > 0) begin
        checks++;
        if (cyc - prev !== 29) begin errors++; $display("FAIL rr_spacing%0d: got %0d expected 29", i, cyc - prev); end
      end
      prev = cyc;
      frame_busy(10);
      wait_idle(n);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    req_data  = 32'hD3D2_D1D0;
    req_valid = 4'b1100;
    for (int j = 0; j < 4; j++) begin
      #1;
      checks++;
      if (req_ready !== (4'b0001 << exp_order[j])) begin
        errors++; $display("FAIL b2b_ready%0d: got %b expected %b", j, req_ready, 4'b0001 << exp_order[j]);
      end
      step();
      checks++;
      if (grant_id !== 2'(exp_order[j])) begin errors++; $display("FAIL b2b_grant%0d: got %0d expected %0d", j, grant_id, exp_order[j]); end
      checks++;
      if (tx_data !== 8'(8'hD0 + exp_order[j])) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", j, tx_data, 8'(8'hD0 + exp_order[j])); end
      req_valid[exp_order[j]] = 1'b0;
      if (j == 0) req_valid = 4'b1101;
      frame_busy(2);
      wait_idle(n);
    end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    req_data  = 32'h0000_3C00;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_ready: got %b expected 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (n !== 64) begin errors++; $display("FAIL to_delay: got %0d cycles expected 64", n); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %b expected 1", busy); end
    req_valid = 4'b0101;
    step();
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", err_timeout); end
    wait_idle(n);
    checks++;
    if (n !== 15) begin errors++; $display("FAIL to_gap: got %0d cycles expected 15", n); end
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_next_grant: got %b expected 0100", req_ready); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_data  = 32'h0000_0011;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    tx_busy = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL mid_in_frame: got busy=%b data=%h expected busy=1 data=11", busy, tx_data); end
    req_valid = 4'b1010;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, grant_id, req_ready, busy, err_timeout} !== 16'h0000) begin
      errors++; $display("FAIL mid_async_clear: got %h expected 0000", {tx_start, tx_data, grant_id, req_ready, busy, err_timeout});
    end
    tx_busy = 1'b0;
    step();
    checks++;
    if (tx_start !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL mid_hold: got start=%b ready=%b expected 0 0000", tx_start, req_ready); end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b expected 0010", req_ready); end
    step();
    checks++;
    if (tx_start !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL mid_first_start: got start=%b id=%0d expected 1 1", tx_start, grant_id); end
  endtask

  task automatic test_gap_zero();
    apply_reset();
    req_data_g  = 32'h0000_775A;
    req_valid_g = 4'b0001;
    #1;
    checks++;
    if (req_ready_g !== 4'b0001) begin errors++; $display("FAIL g0_ready: got %b expected 0001", req_ready_g); end
    step();
    req_valid_g = 4'b0010;
    checks++;
    if (tx_start_g !== 1'b1 || tx_data_g !== 8'h5A) begin errors++; $display("FAIL g0_start: got start=%b data=%h expected 1 5a", tx_start_g, tx_data_g); end
    step();
    tx_busy_g = 1'b1;
    repeat (3) step();
    tx_busy_g = 1'b0;
    #1;
    checks++;
    if (busy_g !== 1'b1 || req_ready_g !== 4'b0000) begin errors++; $display("FAIL g0_still_done: got busy=%b ready=%b expected 1 0000", busy_g, req_ready_g); end
    step();
    #1;
    checks++;
    if (busy_g !== 1'b0) begin errors++; $display("FAIL g0_idle: got %b expected 0", busy_g); end
    checks++;
    if (req_ready_g !== 4'b0010) begin errors++; $display("FAIL g0_accept: got %b expected 0010", req_ready_g); end
    step();
    checks++;
    if (tx_start_g !== 1'b1 || grant_id_g !== 2'd1 || tx_data_g !== 8'h77) begin
      errors++; $display("FAIL g0_second: got start=%b id=%0d data=%h expected 1 1 77", tx_start_g, grant_id_g, tx_data_g);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_gap_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one UART transmitter.
REQ-002 Parameter DATA_W, default 8: byte width per requester.
REQ-003 Parameter GAP_CYCLES, default 16: idle clk cycles enforced between frames; 0 is legal.
REQ-004 Parameter ACK_TIMEOUT, default 64: max clk cycles from tx_start to tx_busy rising.
REQ-005 clk  in  1  system clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-low: 0 = reset.
REQ-007 req_valid  in  NUM_REQ  per-requester byte-pending flag; held until accepted.
REQ-008 req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_ready  out  NUM_REQ  one-hot accept strobe; byte i is taken on the edge where valid[i] and ready[i] are both high.
REQ-010 tx_busy  in  1  UART transmitter busy; high while a frame shifts out.
REQ-011 tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-012 tx_data  out  DATA_W  byte to transmit; stable from tx_start until tx_busy falls.
REQ-013 grant_id  out  clog2(NUM_REQ)  index of the requester currently being served.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 err_timeout  out  1  one-cycle pulse when ACK_TIMEOUT expires.

Function
REQ-016 States: IDLE, START, WAIT_ACK, WAIT_DONE, GAP.
REQ-017 IDLE: if any req_valid is high, assert req_ready for the winner only, combinationally in the same cycle; capture the winner's byte into tx_data and its index into grant_id; go to START.
REQ-018 Arbitration is round-robin: search begins at last_grant+1 modulo NUM_REQ and wraps; after reset last_grant = NUM_REQ-1, so requester 0 has first priority.
REQ-019 last_grant updates only on an accept.
REQ-020 START: tx_start = 1 for exactly one cycle; go to WAIT_ACK.
REQ-021 WAIT_ACK: timeout counter increments each cycle. If tx_busy = 1, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT with tx_busy still 0, pulse err_timeout and go to GAP; the byte is dropped and not retried.
REQ-022 WAIT_DONE: on tx_busy = 0, go to GAP, or go straight to IDLE when GAP_CYCLES = 0.
REQ-023 GAP: count GAP_CYCLES cycles, then go to IDLE; req_ready stays 0.
REQ-024 Latency: valid accepted in cycle n produces tx_start in cycle n+1. Minimum accept-to-accept spacing = 3 + busy duration + GAP_CYCLES cycles.
REQ-025 req_ready is 0 in all states except IDLE; at most one bit is set at a time.
REQ-026 req_valid changes outside IDLE are ignored, and deasserting valid before it is accepted is legal.
REQ-027 tx_busy already high in IDLE or START has no effect; only WAIT_ACK samples it for the ack.
REQ-028 Counters are wide enough for max(GAP_CYCLES, ACK_TIMEOUT) and are cleared on every state entry.

Reset
REQ-029 While rst = 0, state = IDLE.
REQ-030 While rst = 0: tx_start = 0, tx_data = 0, grant_id = 0, req_ready = 0, busy = 0, err_timeout = 0, counters = 0, last_grant = NUM_REQ-1.
REQ-031 Reset asserted mid-frame aborts at once with no further tx_start; the first accept after release obeys REQ-018.

Structure
REQ-032 A shared package holds the state enumeration, the default GAP_CYCLES and ACK_TIMEOUT constants, and a clog2 function.
REQ-033 A single sub-module, rr_arbiter, holds the round-robin pointer and the one-hot winner logic. The FSM, counters and data register stay in uart_tx_arbiter.

Verification
REQ-034 After reset, valid = 4'b0001 with data0 = 8'h95 -> ready[0] in the same cycle; next cycle tx_start = 1 and tx_data = 8'h95; grant_id = 0.
REQ-035 All four valid, each held until accepted; bytes 8'hA0..8'hA3 -> accept order 0,1,2,3. With tx_busy modelled at 10 cycles, successive tx_start pulses are 29 cycles apart (GAP 16).
REQ-036 Back-to-back contention: requester 2 re-requests right after being served while 3 is pending -> next grant is 3, then 0, then 2.
REQ-037 tx_busy held 0 after tx_start -> err_timeout pulses exactly 64 cycles after tx_start; FSM then runs GAP and returns to IDLE; the next accept goes to the next requester.
REQ-038 rst driven low during WAIT_DONE -> all outputs 0 within the same cycle, asynchronously; after release, a pending valid[1] and valid[3] -> grant 1.
REQ-039 GAP_CYCLES = 0 build: tx_busy falling -> IDLE on the next edge and accept of the pending request in that cycle.
